calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Command sequencer and controller for the shared byte-calculator ALU on the BASYS 3 calculator design.
- Takes debounced button levels, edge-detects and prioritises them, and latches switch operands.
- Issues one request/acknowledge transaction per command to the ALU, waits for completion with a watchdog, and holds the result and status for the LED display.
- Sits between the btn_debouncer instances and the calculator datapath.

Parameters:
- WIDTH, 8, operand width in bits.
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT before the ALU is declared hung.

Ports:
- clk_100MHz  in   1  system clock, 100 MHz; all logic rising-edge.
- reset  in   1  asynchronous, active-low reset (0 = reset).
- cmd_btn  in  5  debounced button levels {clear, add, sub, mult, div}, bit 4 = clear.
- sw_a  in  WIDTH  operand A (switches).
- sw_b  in  WIDTH  operand B (switches).
- alu_req  out  1  request valid to ALU.
- alu_op  out  3  operation code (package encoding).
- alu_a  out  WIDTH  latched operand A.
- alu_b  out  WIDTH  latched operand B.
- alu_ready  in  1  ALU accepts the request this cycle.
- alu_done  in  1  ALU result valid this cycle.
- alu_result  in  2*WIDTH  ALU result.
- alu_abort  out  1  one-cycle pulse telling the ALU to drop any in-flight operation.
- result  out  2*WIDTH  last captured result.
- result_valid  out  1  one-cycle pulse when result updates.
- busy  out  1  high in ISSUE or WAIT.
- err_div0  out  1  sticky; divide attempted with B = 0.
- err_timeout  out  1  sticky; ALU failed to complete within TIMEOUT_CYCLES.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0, state IDLE, watchdog counter 0.
  - Previous-button register set to 5'b11111, so a button held through reset release produces no command.
- Edge detect: rise = cmd_btn & ~prev. prev <= cmd_btn every cycle. A held button yields exactly one command.
- Priority when several rises occur in one cycle: clear > add > sub > mult > div. Losing rises are discarded, not queued.
- Clear rise, any state:
  - Next state IDLE; result <= 0; err_div0, err_timeout <= 0.
  - alu_abort pulses 1 cycle only if the state was ISSUE or WAIT.
  - alu_req <= 0.
- IDLE, op rise accepted at clock edge k:
  - Latch alu_a = sw_a, alu_b = sw_b, alu_op = code. err_div0 and err_timeout clear on accept.
  - If op = div and sw_b = 0: err_div0 <= 1, result <= 0, no ALU request, remain IDLE, no result_valid.
  - Otherwise go to ISSUE; alu_req = 1 visible from cycle k+1.
- ISSUE:
  - alu_req held with stable op and operands until alu_ready = 1.
  - On req & ready: alu_req <= 0, counter <= 0, go to WAIT.
  - If alu_done is also 1 in the accept cycle: capture alu_result, pulse result_valid, go directly to IDLE.
  - The watchdog also runs in ISSUE: ready absent for TIMEOUT_CYCLES cycles gives the timeout action below.
- WAIT:
  - Counter increments each cycle.
  - alu_done = 1: result <= alu_result, result_valid pulse next cycle, go to IDLE.
  - Counter reaching TIMEOUT_CYCLES without done: err_timeout <= 1, alu_abort pulse, result unchanged, go to IDLE.
  - If done and timeout coincide, done wins.
- Non-clear rises while busy are ignored.
- alu_done outside ISSUE/WAIT is ignored.
- result is zero-extended as delivered by the ALU; this block performs no arithmetic.
- busy = (state != IDLE), registered.

Decomposition:
- Package calc_pkg holds:
  - op codes OP_NONE=0, OP_ADD=1, OP_SUB=2, OP_MUL=3, OP_DIV=4
  - button bit indices BTN_CLR=4, BTN_ADD=3, BTN_SUB=2, BTN_MUL=1, BTN_DIV=0
  - state encoding IDLE/ISSUE/WAIT
- One sub-module: btn_edge_arbiter. It holds the prev register, rise detection and priority encode, and outputs cmd_valid, cmd_clear and cmd_op. It resets with prev = all ones.

Test Plan:
- Reset release with cmd_btn=5'b01000 held, then stay held 20 cycles -> no alu_req. Release and re-press add -> exactly one alu_req.
- sw_a=8'd200, sw_b=8'd100, press mult; ALU ready after 3 cycles, done 4 cycles later with 16'd20000 -> alu_op=3, result=16'd20000, one result_valid pulse, busy low after done.
- sw_b=0, press div -> err_div0=1, result=0, alu_req never asserted. Next add with sw_b=5 -> err_div0 clears.
- add and sub rise in the same cycle, sw_a=7, sw_b=3 -> alu_op=1 only, no subsequent sub request.
- ALU accepts but never asserts done -> after TIMEOUT_CYCLES (255) in WAIT: err_timeout=1, alu_abort pulse, result unchanged.
- Press clear while in WAIT -> alu_abort pulse, state IDLE next cycle, result=0, flags 0. A late alu_done is then ignored.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings for the calculator sequencer: ALU op codes, button bit positions, FSM states.
package calc_pkg;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;

    localparam int BTN_CLR = 4;
    localparam int BTN_ADD = 3;
    localparam int BTN_SUB = 2;
    localparam int BTN_MUL = 1;
    localparam int BTN_DIV = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/calc_sequencer_btn_edge_arbiter.sv
// Rising-edge detect on debounced buttons with fixed priority clear > add > sub > mult > div.
module btn_edge_arbiter
    import calc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn,
    output logic       cmd_valid,
    output logic       cmd_clear,
    output logic [2:0] cmd_op
);

    logic [4:0] prev;
    logic [4:0] rise;

    // All-ones reset: a button held through reset release must not look like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= '1;
        else        prev <= btn;
    end

    assign rise      = btn & ~prev;
    assign cmd_valid = |rise;
    assign cmd_clear = rise[BTN_CLR];

    always_comb begin
        cmd_op = OP_NONE;
        if      (rise[BTN_ADD]) cmd_op = OP_ADD;
        else if (rise[BTN_SUB]) cmd_op = OP_SUB;
        else if (rise[BTN_MUL]) cmd_op = OP_MUL;
        else if (rise[BTN_DIV]) cmd_op = OP_DIV;
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator command sequencer: one req/ack ALU transaction per button press, with watchdog and sticky errors.
//   state | meaning
//   IDLE  | waiting for a command; result and flags held
//   ISSUE | alu_req high, waiting for alu_ready
//   WAIT  | request accepted, waiting for alu_done
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic [4:0]         cmd_btn,
    input  logic [WIDTH-1:0]   sw_a,
    input  logic [WIDTH-1:0]   sw_b,
    output logic               alu_req,
    output logic [2:0]         alu_op,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic               alu_ready,
    input  logic               alu_done,
    input  logic [2*WIDTH-1:0] alu_result,
    output logic               alu_abort,
    output logic [2*WIDTH-1:0] result,
    output logic               result_valid,
    output logic               busy,
    output logic               err_div0,
    output logic               err_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] count;
    logic          cmd_valid;
    logic          cmd_clear;
    logic [2:0]    cmd_op;

    btn_edge_arbiter u_arb (
        .clk       (clk_100MHz),
        .rst_n     (reset),
        .btn       (cmd_btn),
        .cmd_valid (cmd_valid),
        .cmd_clear (cmd_clear),
        .cmd_op    (cmd_op)
    );

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            alu_req      <= 1'b0;
            alu_op       <= OP_NONE;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_abort    <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            err_div0     <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            alu_abort    <= 1'b0;
            result_valid <= 1'b0;
            if (cmd_clear) begin
                alu_abort   <= (state != IDLE);
                state       <= IDLE;
                busy        <= 1'b0;
                alu_req     <= 1'b0;
                count       <= '0;
                result      <= '0;
                err_div0    <= 1'b0;
                err_timeout <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_valid) begin
                            alu_a       <= sw_a;
                            alu_b       <= sw_b;
                            alu_op      <= cmd_op;
                            err_timeout <= 1'b0;
                            if (cmd_op == OP_DIV && sw_b == '0) begin
                                err_div0 <= 1'b1;
                                result   <= '0;
                            end else begin
                                err_div0 <= 1'b0;
                                state    <= ISSUE;
                                busy     <= 1'b1;
                                alu_req  <= 1'b1;
                                count    <= '0;
                            end
                        end
                    end
                    ISSUE: begin
                        if (alu_ready) begin
                            alu_req <= 1'b0;
                            count   <= '0;
                            if (alu_done) begin
                                result       <= alu_result;
                                result_valid <= 1'b1;
                                state        <= IDLE;
                                busy         <= 1'b0;
                            end else begin
                                state <= WAIT;
                            end
                        end else if (count == TO_LAST) begin
                            alu_req     <= 1'b0;
                            err_timeout <= 1'b1;
                            alu_abort   <= 1'b1;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    WAIT: begin
                        // done takes precedence over a coincident watchdog expiry
                        if (alu_done) begin
                            result       <= alu_result;
                            result_valid <= 1'b1;
                            state        <= IDLE;
                            busy         <= 1'b0;
                        end else if (count == TO_LAST) begin
                            err_timeout <= 1'b1;
                            alu_abort   <= 1'b1;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer; the bench plays the ALU by hand.
module tb_calc_sequencer;

    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic [4:0]  cmd_btn;
    logic [7:0]  sw_a, sw_b;
    logic        alu_req;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic        alu_ready, alu_done;
    logic [15:0] alu_result;
    logic        alu_abort;
    logic [15:0] result;
    logic        result_valid, busy, err_div0, err_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int req_rises = 0;
    int rv_pulses = 0;
    int abort_pulses = 0;
    logic req_q = 1'b0;

    calc_sequencer #(.WIDTH(8), .TIMEOUT_CYCLES(255)) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .cmd_btn     (cmd_btn),
        .sw_a        (sw_a),
        .sw_b        (sw_b),
        .alu_req     (alu_req),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ready   (alu_ready),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .alu_abort   (alu_abort),
        .result      (result),
        .result_valid(result_valid),
        .busy        (busy),
        .err_div0    (err_div0),
        .err_timeout (err_timeout)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(negedge clk_100MHz) begin
        if (alu_req && !req_q) req_rises++;
        if (result_valid) rv_pulses++;
        if (alu_abort) abort_pulses++;
        req_q = alu_req;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_100MHz);
            #1;
        end
    endtask

    task automatic test_reset();
        int r0;
        reset = 1'b0; cmd_btn = 5'b01000; sw_a = 8'd30; sw_b = 8'd12;
        alu_ready = 0; alu_done = 0; alu_result = '0;
        tick(3);
        n_cmp++; if ({alu_req, alu_abort, result_valid, busy, err_div0, err_timeout} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags got=%b want=000000", {alu_req, alu_abort, result_valid, busy, err_div0, err_timeout});
        end
        n_cmp++; if ({result, alu_op, alu_a, alu_b} !== 35'd0) begin
            n_err++; $display("FAIL reset_data result=%0d op=%0d a=%0d b=%0d want all 0", result, alu_op, alu_a, alu_b);
        end
        @(negedge clk_100MHz); reset = 1'b1;
        tick(20);
        n_cmp++; if (req_rises !== 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL held_through_reset req_rises=%0d busy=%b want 0/0", req_rises, busy);
        end
        cmd_btn = 5'b00000; tick(2);
        r0 = req_rises;
        cmd_btn = 5'b01000; tick(1);
        n_cmp++; if (alu_req !== 1'b1 || alu_op !== 3'd1 || busy !== 1'b1) begin
            n_err++; $display("FAIL add_issue req=%b op=%0d busy=%b want 1/1/1", alu_req, alu_op, busy);
        end
        alu_ready = 1; alu_done = 1; alu_result = 16'd42; tick(1);
        alu_ready = 0; alu_done = 0;
        n_cmp++; if (result !== 16'd42 || result_valid !== 1'b1 || busy !== 1'b0 || alu_req !== 1'b0) begin
            n_err++; $display("FAIL accept_with_done result=%0d rv=%b busy=%b req=%b want 42/1/0/0", result, result_valid, busy, alu_req);
        end
        tick(5);
        n_cmp++; if (req_rises - r0 !== 1) begin
            n_err++; $display("FAIL single_req got=%0d want=1", req_rises - r0);
        end
        cmd_btn = 5'b00000; tick(2);
    endtask

    task automatic test_mult();
        int rv0;
        rv0 = rv_pulses;
        sw_a = 8'd200; sw_b = 8'd100; cmd_btn = 5'b00010; tick(1);
        sw_a = 8'd1; sw_b = 8'd2;
        n_cmp++; if (alu_req !== 1'b1 || alu_op !== 3'd3 || alu_a !== 8'd200 || alu_b !== 8'd100) begin
            n_err++; $display("FAIL mult_issue req=%b op=%0d a=%0d b=%0d want 1/3/200/100", alu_req, alu_op, alu_a, alu_b);
        end
        tick(2);
        n_cmp++; if (alu_req !== 1'b1 || alu_a !== 8'd200 || busy !== 1'b1) begin
            n_err++; $display("FAIL mult_hold req=%b a=%0d busy=%b want 1/200/1", alu_req, alu_a, busy);
        end
        alu_ready = 1; tick(1); alu_ready = 0;
        n_cmp++; if (alu_req !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL mult_wait req=%b busy=%b want 0/1", alu_req, busy);
        end
        tick(3);
        alu_done = 1; alu_result = 16'd20000; tick(1); alu_done = 0;
        n_cmp++; if (result !== 16'd20000 || result_valid !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL mult_done result=%0d rv=%b busy=%b want 20000/1/0", result, result_valid, busy);
        end
        tick(3);
        n_cmp++; if (rv_pulses - rv0 !== 1 || result_valid !== 1'b0) begin
            n_err++; $display("FAIL mult_rv_pulses got=%0d want=1", rv_pulses - rv0);
        end
        cmd_btn = 5'b00000; tick(2);
    endtask

    task automatic test_div0();
        int r0, rv0;
        r0 = req_rises; rv0 = rv_pulses;
        sw_a = 8'd9; sw_b = 8'd0; cmd_btn = 5'b00001; tick(1);
        n_cmp++; if (err_div0 !== 1'b1 || result !== 16'd0 || alu_req !== 1'b0 || busy !== 1'b0 || alu_op !== 3'd4) begin
            n_err++; $display("FAIL div0 err=%b result=%0d req=%b busy=%b op=%0d want 1/0/0/0/4", err_div0, result, alu_req, busy, alu_op);
        end
        tick(4);
        n_cmp++; if (req_rises !== r0 || rv_pulses !== rv0 || err_div0 !== 1'b1) begin
            n_err++; $display("FAIL div0_no_req reqs=%0d rvs=%0d err=%b want %0d/%0d/1", req_rises, rv_pulses, err_div0, r0, rv0);
        end
        cmd_btn = 5'b00000; tick(1);
        sw_a = 8'd7; sw_b = 8'd5; cmd_btn = 5'b01000; tick(1);
        n_cmp++; if (err_div0 !== 1'b0 || alu_req !== 1'b1 || alu_b !== 8'd5) begin
            n_err++; $display("FAIL div0_clear err=%b req=%b b=%0d want 0/1/5", err_div0, alu_req, alu_b);
        end
        alu_ready = 1; alu_done = 1; alu_result = 16'd12; tick(1);
        alu_ready = 0; alu_done = 0;
        cmd_btn = 5'b00000; tick(2);
    endtask

    task automatic test_priority();
        int r0;
        r0 = req_rises;
        sw_a = 8'd7; sw_b = 8'd3; cmd_btn = 5'b01100; tick(1);
        n_cmp++; if (alu_op !== 3'd1 || alu_req !== 1'b1) begin
            n_err++; $display("FAIL prio_op got=%0d req=%b want 1/1", alu_op, alu_req);
        end
        alu_ready = 1; tick(1); alu_ready = 0;
        alu_done = 1; alu_result = 16'd10; tick(1); alu_done = 0;
        n_cmp++; if (result !== 16'd10) begin
            n_err++; $display("FAIL prio_result got=%0d want=10", result);
        end
        tick(5);
        n_cmp++; if (req_rises - r0 !== 1 || busy !== 1'b0) begin
            n_err++; $display("FAIL prio_no_sub reqs=%0d busy=%b want 1/0", req_rises - r0, busy);
        end
        cmd_btn = 5'b00000; tick(2);
    endtask

    task automatic test_timeout();
        int a0, n;
        a0 = abort_pulses; n = 0;
        cmd_btn = 5'b01000; tick(1);
        alu_ready = 1; tick(1); alu_ready = 0;
        cmd_btn = 5'b00000;
        while (err_timeout !== 1'b1 && n < 300) begin
            tick(1); n++;
        end
        n_cmp++; if (n < 254 || n > 256) begin
            n_err++; $display("FAIL timeout_cycles got=%0d want about 255", n);
        end
        n_cmp++; if (alu_abort !== 1'b1 || busy !== 1'b0 || result !== 16'd10) begin
            n_err++; $display("FAIL timeout_state abort=%b busy=%b result=%0d want 1/0/10", alu_abort, busy, result);
        end
        tick(2);
        n_cmp++; if (abort_pulses - a0 !== 1 || err_timeout !== 1'b1) begin
            n_err++; $display("FAIL timeout_pulse aborts=%0d err=%b want 1/1", abort_pulses - a0, err_timeout);
        end
    endtask

    task automatic test_clear_wait();
        int a0, rv0;
        cmd_btn = 5'b01000; tick(1);
        alu_ready = 1; tick(1); alu_ready = 0;
        tick(3);
        a0 = abort_pulses; rv0 = rv_pulses;
        cmd_btn = 5'b11000; tick(1);
        n_cmp++; if (alu_abort !== 1'b1 || busy !== 1'b0 || result !== 16'd0 || err_timeout !== 1'b0 || err_div0 !== 1'b0) begin
            n_err++; $display("FAIL clear_wait abort=%b busy=%b result=%0d errs=%b%b want 1/0/0/00", alu_abort, busy, result, err_div0, err_timeout);
        end
        alu_done = 1; alu_result = 16'd99; tick(1); alu_done = 0;
        tick(1);
        n_cmp++; if (result !== 16'd0 || rv_pulses !== rv0 || abort_pulses - a0 !== 1) begin
            n_err++; $display("FAIL late_done result=%0d rvs=%0d aborts=%0d want 0/%0d/1", result, rv_pulses, abort_pulses - a0, rv0);
        end
        cmd_btn = 5'b00000; tick(1);
        cmd_btn = 5'b10000; tick(1);
        n_cmp++; if (alu_abort !== 1'b0) begin
            n_err++; $display("FAIL clear_idle_abort got=%b want=0", alu_abort);
        end
        cmd_btn = 5'b00000; tick(2);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div0();
        test_priority();
        test_timeout();
        test_clear_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
